// File: rtl/demux1to4_16bit_reg.sv
// Registered 1-to-4 demultiplexer: routes one word per cycle from a single source
// into one of four one-entry channel registers, each with its own valid/ready handshake.
module demux1to4_16bit_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] ins,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] outs0,
    output logic [WIDTH-1:0] outs1,
    output logic [WIDTH-1:0] outs2,
    output logic [WIDTH-1:0] outs3,
    output logic [15:0]      routed_count
);

    logic [15:0] count_reg;
    logic        acc;

    // Ready depends only on the addressed channel, so a stalled sink blocks only its own words.
    assign in_ready = ~flush & (~out_valid[select] | out_ready[select]);
    assign acc      = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_ch
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic             load;

            assign load = acc && (select == 2'(gi));

            // Load wins over drain, so a simultaneous take and refill keeps valid high.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (load) begin
                    valid_reg <= 1'b1;
                    data_reg  <= ins;
                end else if (valid_reg && out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi] = valid_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 16'h0000;
        end else if (flush) begin
            count_reg <= 16'h0000;
        end else if (acc) begin
            count_reg <= count_reg + 16'h0001;
        end
    end

    assign outs0        = gen_ch[0].data_reg;
    assign outs1        = gen_ch[1].data_reg;
    assign outs2        = gen_ch[2].data_reg;
    assign outs3        = gen_ch[3].data_reg;
    assign routed_count = count_reg;

endmodule

// File: tb/tb_demux1to4_16bit_reg.sv
// Scoreboard bench for demux1to4_16bit_reg: accepted words are queued per channel and
// checked by a monitor when each sink takes them; directed checks cover reset, flush and wrap.
module tb_demux1to4_16bit_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  select = 2'b00;
    logic [15:0] ins = 16'h0000;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'b0000;
    logic [15:0] outs0, outs1, outs2, outs3;
    logic [15:0] routed_count;
    logic [15:0] outs_w [4];
    logic [15:0] exp_q [4][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux1to4_16bit_reg #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .select(select), .ins(ins),
        .out_valid(out_valid), .out_ready(out_ready),
        .outs0(outs0), .outs1(outs1), .outs2(outs2), .outs3(outs3),
        .routed_count(routed_count)
    );

    assign outs_w[0] = outs0;
    assign outs_w[1] = outs1;
    assign outs_w[2] = outs2;
    assign outs_w[3] = outs3;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic clear_queues();
        for (int c = 0; c < 4; c++) exp_q[c].delete();
    endtask

    // Presents one word for one cycle; queues it only if the block reports ready.
    task automatic send(input logic [15:0] d, input logic [1:0] s, input logic exp_rdy, input bit quiet);
        in_valid = 1'b1;
        ins      = d;
        select   = s;
        @(negedge clk);
        check("in_ready", {15'b0, in_ready}, {15'b0, exp_rdy});
        if (in_ready) exp_q[s].push_back(d);
        if (!quiet) $display("send ch%0d data=%h ready=%0b count=%h", s, d, in_ready, routed_count);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every sink take is compared against the oldest queued word of that channel.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            for (int c = 0; c < 4; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL drain_ch%0d: got %h expected no word", c, outs_w[c]);
                    end else begin
                        if (outs_w[c] !== exp_q[c][0]) begin
                            errors++;
                            $display("FAIL drain_ch%0d: got %h expected %h", c, outs_w[c], exp_q[c][0]);
                        end
                        void'(exp_q[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", {12'b0, out_valid}, 16'h0000);
        check("rst_outs0", outs0, 16'h0000);
        check("rst_outs3", outs3, 16'h0000);
        check("rst_count", routed_count, 16'h0000);
        check("rst_in_ready", {15'b0, in_ready}, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Reset then route
        out_ready = 4'b1111;
        send(16'hA5A5, 2'b10, 1'b1, 1'b0);
        check("route_valid", {12'b0, out_valid}, 16'h0004);
        check("route_outs2", outs2, 16'hA5A5);
        idle(1);
        check("route_valid_clr", {12'b0, out_valid}, 16'h0000);
        check("route_count", routed_count, 16'h0001);

        // Back-to-back on channel 1, no bubble
        out_ready = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            send(16'(k), 2'b01, 1'b1, 1'b0);
            check("b2b_outs1", outs1, 16'(k));
            check("b2b_valid", {12'b0, out_valid}, 16'h0002);
        end
        check("b2b_count", routed_count, 16'h0005);
        idle(1);

        // Blocked channel isolation
        out_ready = 4'b1110;
        send(16'h1111, 2'b00, 1'b1, 1'b0);
        send(16'h2222, 2'b00, 1'b0, 1'b0);
        send(16'h3333, 2'b11, 1'b1, 1'b0);
        check("iso_outs3", outs3, 16'h3333);
        check("iso_outs0", outs0, 16'h1111);
        out_ready = 4'b1111;
        send(16'h2222, 2'b00, 1'b1, 1'b0);
        check("iso_outs0_new", outs0, 16'h2222);
        check("iso_count", routed_count, 16'h0008);
        idle(1);

        // Flush priority over a pending accept
        out_ready = 4'b0000;
        send(16'hAAAA, 2'b00, 1'b1, 1'b0);
        send(16'hBBBB, 2'b11, 1'b1, 1'b0);
        check("fl_valid_pre", {12'b0, out_valid}, 16'h0009);
        flush = 1'b1;
        send(16'hCCCC, 2'b01, 1'b0, 1'b0);
        flush = 1'b0;
        clear_queues();
        check("fl_valid", {12'b0, out_valid}, 16'h0000);
        check("fl_count", routed_count, 16'h0000);
        check("fl_outs0", outs0, 16'hAAAA);
        check("fl_outs3", outs3, 16'hBBBB);
        check("fl_outs1", outs1, 16'h0004);

        // Asynchronous reset between edges
        send(16'hDDDD, 2'b10, 1'b1, 1'b0);
        check("ar_valid_pre", {12'b0, out_valid}, 16'h0004);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {12'b0, out_valid}, 16'h0000);
        check("ar_outs2", outs2, 16'h0000);
        check("ar_count", routed_count, 16'h0000);
        clear_queues();
        $display("async reset applied mid-cycle");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Counter wrap with sustained full throughput on all channels
        out_ready = 4'b1111;
        for (int k = 0; k < 65535; k++) send(16'(k), 2'(k % 4), 1'b1, 1'b1);
        $display("wrap preload done count=%h", routed_count);
        check("wrap_ffff", routed_count, 16'hFFFF);
        send(16'hBEEF, 2'b01, 1'b1, 1'b0);
        check("wrap_zero", routed_count, 16'h0000);
        idle(2);

        for (int c = 0; c < 4; c++) check("queue_empty", 16'(exp_q[c].size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
